vga_sync_frame_core: RTL and testbench
======================================

Name: vga_sync_frame_core

Overview:
- Timing and output stage of the video pipeline. Generates the 640x480 pixel tick and the x/y frame counters that drive the sprite and log cores.
- Consumes the final so_rgb of the last sprite stage. Delays hsync/vsync/blanking to match the stream latency, and drives the VGA pins.
- Exposes a frame counter and a vertical-blank status over the video slot interface. Software uses these to update sprite registers tear-free.

Parameters:
CD, 12, color depth of stream and output
HD, 640, horizontal display pixels
HF, 16, horizontal front porch
HB, 48, horizontal back porch
HR, 96, horizontal retrace (sync width)
VD, 480, vertical display lines
VF, 10, vertical front porch
VB, 33, vertical back porch
VR, 2, vertical retrace
PIX_DIV, 4, system clocks per pixel tick (>=2)
PIPE_DLY, 2, clk latency of upstream stream stages (0..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cs  in  1  slot select
read  in  1  read strobe
write  in  1  write strobe
addr  in  2  register address
wr_data  in  32  write data
rd_data  out  32  read data (combinational on addr)
si_rgb  in  CD  stream from last sprite stage
x  out  11  current pixel column counter
y  out  11  current line counter
p_tick  out  1  one-clk pixel enable
frame_start  out  1  one-clk pulse at (0,0) entry
hsync  out  1  active-low horizontal sync to pin
vsync  out  1  active-low vertical sync to pin
rgb  out  CD  pixel to pin

Behaviour:
- Totals: HT=HD+HF+HB+HR (800), VT=VD+VF+VB+VR (525).
- Reset (reset=0, asynchronous): divider=0, x=0, y=0, p_tick=0, frame_start=0, frame_cnt=0, all delay-line stages hold hsync=1/vsync=1/video_on=0, rgb=0. Outputs hold these values until reset is released.
- Divider:
  - Counts 0..PIX_DIV-1 and wraps.
  - p_tick=1 exactly when divider==PIX_DIV-1. First tick is on the PIX_DIV-th clock after reset release.
- Counters (advance only on p_tick):
  - x increments, wrapping HT-1->0.
  - On x wrap, y increments, wrapping VT-1->0.
  - x and y are registered and hold for PIX_DIV clocks.
- frame_start=1 for the single clock on which p_tick=1, x==HT-1 and y==VT-1.
- Raw timing, derived combinationally from x/y:
  - video_on_raw = (x<HD)&&(y<VD).
  - hs_raw = 0 for HD+HF <= x <= HD+HF+HR-1, else 1.
  - vs_raw = 0 for VD+VF <= y <= VD+VF+VR-1, else 1.
- Alignment:
  - video_on_raw passes through a PIPE_DLY-deep clk shift register. PIPE_DLY=0 means the raw value is used directly.
  - rgb register: rgb <= video_on_d ? si_rgb : 0.
  - hs_raw and vs_raw pass through PIPE_DLY+1 clk stages, so hsync/vsync align with rgb.
  - All delay stages shift every clk, not on p_tick.
- frame_cnt (32 bit):
  - Increments on frame_start and wraps at 2^32-1 -> 0.
  - A write to addr 0 clears it. If the clear and frame_start occur in the same clk, the clear wins (result 0).
- Read map (rd_data, independent of read/cs):
  - addr 0: frame_cnt.
  - addr 1: {20'b0, vblank, y}, where vblank=(y>=VD).
  - addr 2: {21'b0, x}.
  - addr 3: 0.
- Write map: addr 0 = clear frame_cnt (wr_data ignored). All other write addresses are ignored.

Test Plan:
- Reset release, defaults -> hsync=1, vsync=1, rgb=0, x=y=0. First p_tick on clk 4; x=1 after it; frame_cnt read = 0.
- Run one line, si_rgb=12'hF0F, PIPE_DLY=2 -> rgb=12'hF0F for exactly 640*4 clks per line, starting 3 clks after x=0 first appears. hsync low for exactly 96*4=384 clks, starting 3 clks after x reaches 656.
- Full frame -> vsync low for 2 lines (y=490,491; 2*800*4=6400 clks). frame_start pulses once per 1,680,000 clks. frame_cnt reads 1 then 2 after two frames. Addr 1 shows vblank=1 for y=480..524.
- Write addr 0 on the same clk as frame_start with frame_cnt=5 -> frame_cnt=0 afterward, not 1. Write addr 2 -> no state change.
- Assert reset mid-line at x=300,y=100 -> outputs return to reset values asynchronously, without waiting for clk. Restart from x=0,y=0 with a fresh divider phase.
- PIPE_DLY=0, si_rgb toggling every clk -> rgb equals si_rgb delayed exactly 1 clk during display and 0 during blanking. hsync/vsync are also 1 clk delayed.

Source files
------------

// File: rtl/vga_sync_frame_core.sv
// VGA timing generator and output stage: pixel divider, x/y scan counters, sync/blank
// alignment to the upstream stream latency, plus a frame counter readable over the slot bus.
module vga_sync_frame_core #(
  parameter int unsigned CD       = 12,
  parameter int unsigned HD       = 640,
  parameter int unsigned HF       = 16,
  parameter int unsigned HB       = 48,
  parameter int unsigned HR       = 96,
  parameter int unsigned VD       = 480,
  parameter int unsigned VF       = 10,
  parameter int unsigned VB       = 33,
  parameter int unsigned VR       = 2,
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [1:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          p_tick,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb
);

  localparam int unsigned HT = HD + HF + HB + HR;
  localparam int unsigned VT = VD + VF + VB + VR;
  localparam int unsigned DW = $clog2(PIX_DIV);
  localparam int unsigned SW = PIPE_DLY + 1;

  localparam logic [DW-1:0] DivMax  = DW'(PIX_DIV - 1);
  localparam logic [10:0]   XMax    = 11'(HT - 1);
  localparam logic [10:0]   YMax    = 11'(VT - 1);
  localparam logic [10:0]   XDisp   = 11'(HD);
  localparam logic [10:0]   YDisp   = 11'(VD);
  localparam logic [10:0]   HsStart = 11'(HD + HF);
  localparam logic [10:0]   HsEnd   = 11'(HD + HF + HR - 1);
  localparam logic [10:0]   VsStart = 11'(VD + VF);
  localparam logic [10:0]   VsEnd   = 11'(VD + VF + VR - 1);

  logic [DW-1:0] div_q, div_d;
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic [SW-1:0] hs_q, hs_d, vs_q, vs_d;
  logic [CD-1:0] rgb_q, rgb_d;
  logic [31:0]   fc_q, fc_d;
  logic          tick;
  logic          last_pix;
  logic          video_on_raw, hs_raw, vs_raw;
  logic          video_on_dly;
  logic          vblank;
  logic          clr;

  // Bus inputs that carry no information for this slot.
  logic unused_inputs;
  assign unused_inputs = ^{read, wr_data};

  // Pixel clock divider
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DivMax) begin
      div_d = '0;
    end
  end

  assign tick     = (div_q == DivMax);
  assign last_pix = (x_q == XMax) && (y_q == YMax);

  // Scan counters
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == XMax) begin
        x_d = '0;
        y_d = (y_q == YMax) ? 11'd0 : y_q + 11'd1;
      end else begin
        x_d = x_q + 11'd1;
      end
    end
  end

  assign video_on_raw = (x_q < XDisp) && (y_q < YDisp);
  assign hs_raw       = !((x_q >= HsStart) && (x_q <= HsEnd));
  assign vs_raw       = !((y_q >= VsStart) && (y_q <= VsEnd));
  assign vblank       = (y_q >= YDisp);

  // Blanking delay matches the upstream stream latency; the rgb register adds one more.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign video_on_dly = video_on_raw;
  end else begin : g_dly
    logic [PIPE_DLY-1:0] von_q, von_d;

    always_comb begin
      von_d[0] = video_on_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        von_d[i] = von_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        von_q <= '0;
      end else begin
        von_q <= von_d;
      end
    end

    assign video_on_dly = von_q[PIPE_DLY-1];
  end

  // Sync delay is one stage longer so it lines up with the registered rgb.
  always_comb begin
    hs_d[0] = hs_raw;
    vs_d[0] = vs_raw;
    for (int i = 1; i < SW; i++) begin
      hs_d[i] = hs_q[i-1];
      vs_d[i] = vs_q[i-1];
    end
  end

  assign rgb_d = video_on_dly ? si_rgb : '0;

  // Frame counter; a software clear takes priority over a coincident frame start.
  assign clr = cs && write && (addr == 2'd0);

  always_comb begin
    fc_d = fc_q;
    if (clr) begin
      fc_d = '0;
    end else if (tick && last_pix) begin
      fc_d = fc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
      rgb_q <= '0;
      fc_q  <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
      fc_q  <= fc_d;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      2'd0:    rd_data = fc_q;
      2'd1:    rd_data = {20'b0, vblank, y_q};
      2'd2:    rd_data = {21'b0, x_q};
      default: rd_data = '0;
    endcase
  end

  assign x           = x_q;
  assign y           = y_q;
  assign p_tick      = tick;
  assign frame_start = tick && last_pix;
  assign hsync       = hs_q[SW-1];
  assign vsync       = vs_q[SW-1];
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_sync_frame_core.sv
// Bench for vga_sync_frame_core on a reduced 25x15 raster: per-cycle model comparison for
// PIPE_DLY=2 and PIPE_DLY=0 instances plus directed literal checks.
module tb_vga_sync_frame_core;
  localparam int CD  = 12;
  localparam int HD  = 16, HF = 2, HB = 3, HR = 4;
  localparam int VD  = 8,  VF = 2, VB = 3, VR = 2;
  localparam int DIV = 4;
  localparam int HT  = HD + HF + HB + HR;  // 25
  localparam int VT  = VD + VF + VB + VR;  // 15

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wdata = 32'd0;
  logic [CD-1:0] si = 12'hF0F;
  logic [CD-1:0] si_prev = '0;
  logic          rnd = 1'b0;

  logic [31:0]   rd_a, rd_b;
  logic [10:0]   x_a, y_a, x_b, y_b;
  logic          pt_a, fs_a, hs_a, vs_a, pt_b, fs_b, hs_b, vs_b;
  logic [CD-1:0] rgb_a, rgb_b;

  int n;     // posedges since reset release
  int fc_m;  // model frame counter
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_sync_frame_core #(
    .CD(CD), .HD(HD), .HF(HF), .HB(HB), .HR(HR), .VD(VD), .VF(VF), .VB(VB), .VR(VR),
    .PIX_DIV(DIV), .PIPE_DLY(2)
  ) u_dut_a (
    .clk(clk), .reset(rst_n), .cs(cs), .read(rd), .write(wr), .addr(addr), .wr_data(wdata),
    .rd_data(rd_a), .si_rgb(si), .x(x_a), .y(y_a), .p_tick(pt_a), .frame_start(fs_a),
    .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a)
  );

  vga_sync_frame_core #(
    .CD(CD), .HD(HD), .HF(HF), .HB(HB), .HR(HR), .VD(VD), .VF(VF), .VB(VB), .VR(VR),
    .PIX_DIV(DIV), .PIPE_DLY(0)
  ) u_dut_b (
    .clk(clk), .reset(rst_n), .cs(cs), .read(rd), .write(wr), .addr(addr), .wr_data(wdata),
    .rd_data(rd_b), .si_rgb(si), .x(x_b), .y(y_b), .p_tick(pt_b), .frame_start(fs_b),
    .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b)
  );

  // Raster model: position is simply the number of whole pixel periods elapsed.
  function automatic int pos(int k);
    return (k / DIV) % (HT * VT);
  endfunction
  function automatic int mx(int k);
    return pos(k) % HT;
  endfunction
  function automatic int my(int k);
    return pos(k) / HT;
  endfunction
  function automatic bit m_tick(int k);
    return (k % DIV) == DIV - 1;
  endfunction
  function automatic bit m_fs(int k);
    return m_tick(k) && (pos(k) == HT * VT - 1);
  endfunction
  function automatic bit m_von(int k);
    if (k < 0) return 1'b0;
    return (mx(k) < HD) && (my(k) < VD);
  endfunction
  function automatic bit m_hs(int k);
    if (k < 0) return 1'b1;
    return !((mx(k) >= HD + HF) && (mx(k) < HD + HF + HR));
  endfunction
  function automatic bit m_vs(int k);
    if (k < 0) return 1'b1;
    return !((my(k) >= VD + VF) && (my(k) < VD + VF + VR));
  endfunction
  function automatic logic [31:0] m_rd(int k, logic [1:0] a, int fc);
    case (a)
      2'd0:    return 32'(fc);
      2'd1:    return {20'b0, my(k) >= VD, 11'(my(k))};
      2'd2:    return {21'b0, 11'(mx(k))};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (n=%0d)", nm, act, exp, n);
    end
  endtask

  task automatic cmp(input string tag, input int p, input logic [10:0] xx, input logic [10:0] yy,
                     input logic pt, input logic fs, input logic hs, input logic vs,
                     input logic [CD-1:0] rg, input logic [31:0] rdd);
    check({tag, "_x"}, 32'(xx), 32'(mx(n)));
    check({tag, "_y"}, 32'(yy), 32'(my(n)));
    check({tag, "_ptick"}, 32'(pt), 32'(m_tick(n) && rst_n));
    check({tag, "_fstart"}, 32'(fs), 32'(m_fs(n) && rst_n));
    check({tag, "_hsync"}, 32'(hs), 32'(m_hs(n - 1 - p)));
    check({tag, "_vsync"}, 32'(vs), 32'(m_vs(n - 1 - p)));
    check({tag, "_rgb"}, 32'(rg), m_von(n - 1 - p) ? 32'(si_prev) : 32'd0);
    check({tag, "_rd"}, rdd, m_rd(n, addr, fc_m));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n    <= 0;
      fc_m <= 0;
    end else begin
      n <= n + 1;
      if (cs && wr && addr == 2'd0) fc_m <= 0;
      else if (m_fs(n)) fc_m <= fc_m + 1;
    end
  end

  always @(posedge clk) si_prev <= si;

  always @(negedge clk) begin
    cmp("a", 2, x_a, y_a, pt_a, fs_a, hs_a, vs_a, rgb_a, rd_a);
    cmp("b", 0, x_b, y_b, pt_b, fs_b, hs_b, vs_b, rgb_b, rd_b);
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd) si = CD'($urandom);
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int rgbc = 0, hsc = 0, vsc = 0, fsc = 0, hs_first = -1, fs_n = -1;
    step(3);
    check("rst_x", 32'(x_a), 32'd0);
    check("rst_hsync", 32'(hs_a), 32'd1);
    check("rst_rgb", 32'(rgb_a), 32'd0);
    rst_n = 1'b1;
    step(2);
    check("no_tick_clk3", 32'(pt_a), 32'd0);
    step(1);
    check("first_tick_clk4", 32'(pt_a), 32'd1);
    check("fc_after_rst", rd_a, 32'd0);
    step(1);
    check("x_after_tick", 32'(x_a), 32'd1);

    while (n < 1600) begin
      step(1);
      if (n >= 100 && n < 200) begin
        if (rgb_a == 12'hF0F) rgbc++;
        if (!hs_a) begin
          hsc++;
          if (hs_first < 0) hs_first = n;
        end
      end
      if (!vs_a && n < 1500) vsc++;
      if (fs_a) begin
        fsc++;
        fs_n = n;
      end
      if (n == 200) rnd = 1'b1;
    end
    check("rgb_cycles_line", 32'(rgbc), 32'd64);
    check("hsync_low_cycles", 32'(hsc), 32'd16);
    check("hsync_first_low", 32'(hs_first), 32'd175);
    check("vsync_low_cycles", 32'(vsc), 32'd200);
    check("frame_start_count", 32'(fsc), 32'd1);
    check("frame_start_at", 32'(fs_n), 32'd1499);
    check("fc_one", rd_a, 32'd1);

    while (n < 2412) step(1);
    addr = 2'd1;
    #1 check("rd_vblank_y", rd_a, 32'h0000_0809);
    addr = 2'd2;
    #1 check("rd_x", rd_a, 32'd3);
    addr = 2'd3;
    #1 check("rd_zero", rd_a, 32'd0);
    addr = 2'd0;

    while (n < 3010) step(1);
    check("fc_two", rd_a, 32'd2);
    while (n < 3020) step(1);
    cs = 1'b1; wr = 1'b1; addr = 2'd2; wdata = 32'hFFFF_FFFF;
    step(1);
    cs = 1'b0; wr = 1'b0; addr = 2'd0;
    step(1);
    check("wr_addr2_ignored", rd_a, 32'd2);

    while (n < 8999) step(1);
    check("fc_five", rd_a, 32'd5);
    check("fs_on_clear_clk", 32'(fs_a), 32'd1);
    cs = 1'b1; wr = 1'b1; addr = 2'd0;
    step(1);
    cs = 1'b0; wr = 1'b0;
    check("clear_wins", rd_a, 32'd0);

    while (n < 9578) step(1);
    #2;
    check("pre_rst_hsync_low", 32'(hs_a), 32'd0);
    check("pre_rst_y", 32'(y_a), 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_x", 32'(x_a), 32'd0);
    check("async_rst_y", 32'(y_a), 32'd0);
    check("async_rst_hsync", 32'(hs_a), 32'd1);
    check("async_rst_rgb", 32'(rgb_a), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("restart_tick", 32'(pt_a), 32'd1);
    step(1);
    check("restart_x", 32'(x_a), 32'd1);
    while (n < 400) step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
